// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   uart_state_t   : frame-level FSM states
//   OVERSAMPLE_DEF : default number of sample ticks per bit
//   calc_div()     : system clocks per sample tick, rounded to nearest, never below 1
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      longint unsigned den;
      longint unsigned quo;
      den = 64'(baud) * 64'(oversample);
      if (den == 64'd0) return 32'd1;
      quo = (64'(clk_freq) + den / 64'd2) / den;
      if (quo == 64'd0) return 32'd1;
      return 32'(quo);
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if -- received-byte handshake between the UART receiver and its consumer.
//   rx_data      : last received byte (holding register)
//   rx_valid     : rx_data holds an unconsumed byte
//   rx_ready     : consumer takes rx_data when high together with rx_valid
//   rx_frame_err : one-clock pulse, stop bit sampled low
//   rx_overrun   : sticky, an unconsumed byte was overwritten
// master = receiver side, slave = consumer side.
interface uart_receiver_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_frame_err;
   logic       rx_overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_frame_err,
      output rx_overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_frame_err,
      input  rx_overrun,
      output rx_ready
   );

endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen -- sample-tick generator, one tick every DIV clocks.
//   clk     : system clock
//   reset_b : asynchronous active-low reset
//   restart : reload the divider so tick phase is aligned to the current edge
//   tick    : one-clock sample strobe
module baud_tick_gen #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic reset_b,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Down-counter; terminal count produces the tick and reloads.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cnt <= '0;
      end else if (restart || (cnt == '0)) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver -- 8N1 UART receiver with oversampled centre sampling and a
// one-deep holding register with valid/ready handshake.
//   clk      : system clock, all state on rising edge
//   reset_b  : asynchronous active-low reset
//   uart_rxd : asynchronous serial line, idle high, LSB first
//   rx_bus   : receive handshake (data, valid, ready, frame error, overrun)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a 1->0 edge on the synchronized line
// ST_START | counting to the start-bit centre, rejecting glitches
// ST_DATA  | sampling 8 data bits at their centres, LSB first
// ST_STOP  | sampling the stop bit; deliver byte or flag framing error
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic            clk,
   input  logic            reset_b,
   input  logic            uart_rxd,
   uart_receiver_if.master rx_bus
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [SW-1:0] HALF_LOAD = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] BIT_LOAD  = SW'(OVERSAMPLE - 1);

   uart_state_t state, state_nxt;
   logic [SW-1:0] smp_cnt, smp_nxt;
   logic [2:0]    bit_cnt, bit_nxt;
   logic [7:0]    shreg, shreg_nxt;

   logic rxd_meta, rxd_sync;
   logic [1:0] flush;
   logic line_hi;
   logic fall;
   logic tick;
   logic restart;
   logic byte_done;
   logic frame_bad;
   logic consume;

   // Synchronizer. The flops reset to 1, so their first outputs after reset
   // do not reflect the line; flush marks when they do. line_hi is the
   // previous observed line level and only tracks real samples, which keeps a
   // line held low through reset from looking like a start edge.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
         flush    <= 2'b00;
         line_hi  <= 1'b0;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_sync <= rxd_meta;
         flush    <= {flush[0], 1'b1};
         if (flush[1]) line_hi <= rxd_sync;
      end
   end

   assign fall = flush[1] & line_hi & ~rxd_sync;

   baud_tick_gen #(
      .DIV(DIV)
   ) u_tick (
      .clk     (clk),
      .reset_b (reset_b),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state   <= ST_IDLE;
         smp_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         smp_cnt <= smp_nxt;
         bit_cnt <= bit_nxt;
         shreg   <= shreg_nxt;
      end
   end

   // smp_cnt counts sample ticks down to the next bit centre.
   always_comb begin
      state_nxt = state;
      smp_nxt   = smp_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      restart   = 1'b0;
      byte_done = 1'b0;
      frame_bad = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (fall) begin
               state_nxt = ST_START;
               smp_nxt   = HALF_LOAD;
               bit_nxt   = '0;
               restart   = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               if (smp_cnt != '0) begin
                  smp_nxt = smp_cnt - SW'(1);
               end else if (!rxd_sync) begin
                  state_nxt = ST_DATA;
                  smp_nxt   = BIT_LOAD;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (smp_cnt != '0) begin
                  smp_nxt = smp_cnt - SW'(1);
               end else begin
                  shreg_nxt = {rxd_sync, shreg[7:1]};
                  smp_nxt   = BIT_LOAD;
                  if (bit_cnt == 3'd7) begin
                     state_nxt = ST_STOP;
                  end else begin
                     bit_nxt = bit_cnt + 3'd1;
                  end
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (smp_cnt != '0) begin
                  smp_nxt = smp_cnt - SW'(1);
               end else begin
                  state_nxt = ST_IDLE;
                  if (rxd_sync) byte_done = 1'b1;
                  else          frame_bad = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign consume = rx_bus.rx_valid & rx_bus.rx_ready;

   // Holding register. A completing byte always wins the load; overrun is
   // only raised when the old byte is lost without being consumed.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rx_bus.rx_data      <= 8'h00;
         rx_bus.rx_valid     <= 1'b0;
         rx_bus.rx_frame_err <= 1'b0;
         rx_bus.rx_overrun   <= 1'b0;
      end else begin
         rx_bus.rx_frame_err <= frame_bad;
         if (byte_done) begin
            rx_bus.rx_data  <= shreg;
            rx_bus.rx_valid <= 1'b1;
            if (rx_bus.rx_valid && !rx_bus.rx_ready) begin
               rx_bus.rx_overrun <= 1'b1;
            end else if (consume) begin
               rx_bus.rx_overrun <= 1'b0;
            end
         end else if (consume) begin
            rx_bus.rx_valid   <= 1'b0;
            rx_bus.rx_overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver -- self-checking bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

   localparam int unsigned CLK_FREQ = 16000000;
   localparam int unsigned BAUD     = 1000000;
   localparam int OS         = 16;
   localparam int FRAME_CLKS = 10 * OS;
   // Negedge (counted from the one where the start bit is driven) at which
   // rx_valid is first seen: 2 synchronizer clocks, 1 clock to register the
   // start edge, start-bit centre at tick OS/2-1, nine more bit periods to the
   // stop centre, then 1 clock for the output register.
   localparam int DONE_OFS   = 2 + 1 + (OS / 2 - 1) + 9 * OS + 1;

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      bit         rdy_done;
      bit         cons;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ovr;
      int         exp_fe;
   } vec_t;

   logic clk      = 1'b0;
   logic reset_b  = 1'b1;
   logic uart_rxd = 1'b1;

   int checks   = 0;
   int failures = 0;
   int fe_total = 0;
   int fe_exp   = 0;

   logic [7:0] m_data  = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_ovr   = 1'b0;

   uart_receiver_if bus();

   uart_receiver #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .uart_rxd (uart_rxd),
      .rx_bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.rx_frame_err === 1'b1) fe_total++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      chk({name, "_valid"}, 32'(bus.rx_valid), 32'(m_valid));
      chk({name, "_data"}, 32'(bus.rx_data), 32'(m_data));
      chk({name, "_ovr"}, 32'(bus.rx_overrun), 32'(m_ovr));
      chk({name, "_fe"}, fe_total, fe_exp);
   endtask

   task automatic model_reset();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   // Byte-level behaviour of the holding register at frame completion.
   task automatic model_frame(input logic [7:0] b, input bit ok, input bit rdy);
      if (ok) begin
         if (m_valid && !rdy)     m_ovr = 1'b0 | 1'b1;
         else if (m_valid && rdy) m_ovr = 1'b0;
         m_data  = b;
         m_valid = 1'b1;
      end else begin
         fe_exp++;
         if (m_valid && rdy) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rdy_done,
                             input int rst_at, output logic v_pre, output logic v_post,
                             output logic [7:0] d_post);
      logic [9:0] bits;
      bits   = {stop_ok, b, 1'b0};
      v_pre  = 1'bx;
      v_post = 1'bx;
      d_post = 8'hxx;
      for (int n = 0; n < FRAME_CLKS; n++) begin
         @(negedge clk);
         if (n == DONE_OFS - 1) v_pre = bus.rx_valid;
         if (n == DONE_OFS) begin
            v_post = bus.rx_valid;
            d_post = bus.rx_data;
         end
         uart_rxd     = bits[n / OS];
         bus.rx_ready = rdy_done && (n == DONE_OFS - 1);
         if (n == rst_at) begin
            reset_b = 1'b0;
            #1;
            chk("rst_mid_data", 32'(bus.rx_data), 32'h00);
            chk("rst_mid_valid", 32'(bus.rx_valid), 32'h0);
            chk("rst_mid_ovr", 32'(bus.rx_overrun), 32'h0);
            chk("rst_mid_fe", 32'(bus.rx_frame_err), 32'h0);
         end
         if (rst_at >= 0 && n == rst_at + 4) reset_b = 1'b1;
      end
      @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ok, input bit rdy, input int gap);
      logic v_pre, v_post, prev_valid;
      logic [7:0] d_post;
      prev_valid = m_valid;
      send_frame(b, ok, rdy, -1, v_pre, v_post, d_post);
      model_frame(b, ok, rdy);
      chk("lat_before", 32'(v_pre), 32'(prev_valid));
      chk("lat_after", 32'(v_post), 32'(m_valid));
      chk("lat_data", 32'(d_post), 32'(m_data));
      repeat (gap) @(negedge clk);
   endtask

   task automatic consume();
      @(negedge clk);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      chk("consume_valid", 32'(bus.rx_valid), 32'(m_valid));
      chk("consume_ovr", 32'(bus.rx_overrun), 32'(m_ovr));
   endtask

   initial begin
      vec_t vecs[10];
      logic v_pre, v_post;
      logic [7:0] d_post;
      int fe_before;

      bus.rx_ready = 1'b0;
      //            data   ok    rdy   cons  valid  data   ovr   fe
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1};
      vecs[2] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 0};
      vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 0};
      vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 0};
      vecs[5] = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 0};
      vecs[6] = '{8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 0};
      vecs[7] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 0};
      vecs[8] = '{8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 0};
      vecs[9] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1};

      #1 reset_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_data", 32'(bus.rx_data), 32'h00);
      chk("rst_valid", 32'(bus.rx_valid), 32'h0);
      chk("rst_ovr", 32'(bus.rx_overrun), 32'h0);
      chk("rst_fe", 32'(bus.rx_frame_err), 32'h0);
      reset_b = 1'b1;
      repeat (6) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         fe_before = fe_total;
         run_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].rdy_done, 4);
         chk("tbl_valid", 32'(bus.rx_valid), 32'(vecs[i].exp_valid));
         chk("tbl_data", 32'(bus.rx_data), 32'(vecs[i].exp_data));
         chk("tbl_ovr", 32'(bus.rx_overrun), 32'(vecs[i].exp_ovr));
         chk("tbl_fe", fe_total - fe_before, vecs[i].exp_fe);
         if (vecs[i].cons) consume();
      end

      // Short low glitch with a byte pending: nothing may change.
      run_frame(8'hE7, 1'b1, 1'b0, 4);
      check_model("pre_glitch");
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk);
      check_model("glitch");
      run_frame(8'hC6, 1'b1, 1'b0, 4);
      check_model("post_glitch");
      consume();

      for (int r = 0; r < 14; r++) begin
         logic [7:0] b;
         bit ok, rdy, cons;
         b    = 8'($urandom_range(0, 255));
         ok   = ($urandom_range(0, 4) != 0);
         rdy  = ($urandom_range(0, 3) == 0);
         cons = ($urandom_range(0, 1) == 1);
         run_frame(b, ok, rdy, int'($urandom_range(1, 12)));
         check_model("rnd");
         if (cons) consume();
      end

      // Reset in the middle of data bit 4 of 0xFF with a pending, overrun byte.
      run_frame(8'h99, 1'b1, 1'b0, 3);
      run_frame(8'h98, 1'b1, 1'b0, 3);
      check_model("pre_rst");
      send_frame(8'hFF, 1'b1, 1'b0, 5 * OS + 4, v_pre, v_post, d_post);
      model_reset();
      repeat (4) @(negedge clk);
      check_model("post_rst");
      run_frame(8'h5A, 1'b1, 1'b0, 4);
      check_model("rst_5a");

      // Reset released with the line held low: no start until the line rises.
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (5) @(negedge clk);
      reset_b = 1'b0;
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      model_reset();
      repeat (200) @(negedge clk);
      check_model("rst_low");
      uart_rxd = 1'b1;
      repeat (10) @(negedge clk);
      run_frame(8'hC3, 1'b1, 1'b0, 4);
      check_model("rst_low_c3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset_b  input  1  asynchronous active-low reset.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rx_data  output  8  last received byte, holding register.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-010 SHALL have port rx_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 SHALL have port rx_overrun  output  1  sticky, an unconsumed byte was overwritten.

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL generate a sample tick every DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)) clocks, DIV clamped to at least 1; the tick counter is free-running in IDLE and restarts at 0 on start detection.
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 IDLE: 1->0 transition of synchronized line -> START, tick-count cleared.
REQ-016 START: at tick OVERSAMPLE/2-1 (bit centre), line low -> DATA; line high -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA: sample every OVERSAMPLE ticks at bit centre, shift into bit[0..7] LSB first; after bit 7 -> STOP.
REQ-018 STOP: at centre sample, line high -> load shift register into rx_data, rx_valid=1 on next clock edge, -> IDLE.
REQ-019 STOP: at centre sample, line low -> rx_frame_err=1 for exactly one clock, byte discarded, rx_data/rx_valid unchanged, -> IDLE; a new start requires the line to return high first.
REQ-020 Handshake: rx_valid && rx_ready at a clock edge consumes the byte; rx_valid falls next cycle unless REQ-022 applies.
REQ-021 Byte completion with rx_valid=1 and rx_ready=0 SHALL overwrite rx_data, keep rx_valid=1, set rx_overrun.
REQ-022 Byte completion in the same cycle as a consume SHALL load the new byte, keep rx_valid=1, not set rx_overrun.
REQ-023 rx_overrun SHALL clear on the next consume (rx_valid && rx_ready).
REQ-024 rx_data SHALL be stable whenever rx_valid=1 except on REQ-021/022 loads.
REQ-025 Latency: rx_valid rises 1 clock after the stop-bit centre tick, plus the 2-clock synchronizer delay relative to the line.

Reset
REQ-026 reset_b low SHALL asynchronously force state IDLE, synchronizer flops to 1, tick and bit counters to 0, rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_overrun=0.
REQ-027 Reset mid-frame SHALL abandon the frame; after release with the line low, no start is detected until a 1->0 transition is seen.

Structure
REQ-028 State enum, DIV computation function and OVERSAMPLE default SHALL live in shared package uart_pkg, reused by the future uart_transmitter.
REQ-029 Tick generation SHALL be sub-module baud_tick_gen (inputs clk, reset_b, restart; output tick); the FSM and holding register stay in uart_receiver.

Verification
REQ-030 Bench SHALL use CLK_FREQ=16000000, BAUD=1000000 (DIV=1, 16 clocks/bit) for all scenarios.
REQ-031 Send 0xA5 with rx_ready=0 -> rx_valid=1, rx_data=0xA5, frame_err never pulses, overrun=0; pulse rx_ready -> rx_valid=0 next cycle.
REQ-032 Send 0x3C with stop bit held low -> one-cycle rx_frame_err, rx_valid stays 0; following 0x81 received correctly.
REQ-033 4-clock low glitch on idle line -> no state leaves IDLE past START, no outputs change.
REQ-034 Send 0x11 then 0x22 without rx_ready -> rx_data=0x22, rx_overrun=1; accept -> overrun=0, valid=0.
REQ-035 Assert rx_ready exactly at completion cycle of second byte -> rx_valid stays 1, rx_data=second byte, overrun=0.
REQ-036 Assert reset_b low in DATA bit 4 of 0xFF -> all outputs at reset values; next 0x5A received correctly.
